// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter: serial widths, request/ack/result
// structs and the requester source enum.
package mem_access_arbiter_pkg;

  localparam int MSHR_NUM             = 2;
  localparam int MEM_READ_SERIAL_NUM  = MSHR_NUM + 1;
  localparam int MEM_WRITE_SERIAL_NUM = MSHR_NUM;
  localparam int MEM_SERIAL_W         = 2;
  localparam int MEM_WSERIAL_W        = 2;
  localparam int MEM_ADDR_W           = 32;
  localparam int MEM_DATA_W           = 64;

  typedef logic [MEM_SERIAL_W-1:0]  MemAccessSerial;
  typedef logic [MEM_WSERIAL_W-1:0] MemWriteSerial;

  typedef enum logic {
    MEM_REQ_SRC_IC = 1'b0,
    MEM_REQ_SRC_DC = 1'b1
  } MemReqSource;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
  } MemReadAccessReq;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } MemAccessReq;

  typedef struct packed {
    logic           ack;
    MemAccessSerial serial;
    MemWriteSerial  wserial;
  } MemAccessReqAck;

  typedef struct packed {
    logic                  valid;
    MemAccessSerial        serial;
    logic [MEM_DATA_W-1:0] data;
  } MemAccessResult;

  typedef struct packed {
    logic          valid;
    MemWriteSerial serial;
  } MemAccessResponse;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of requester, memory and forwarding signals around the arbiter.
// Handshake: a requester holds .valid until it sees .ack; memReq transfers when memReq.valid && memReqReady.
interface mem_access_arbiter_if;
  import mem_access_arbiter_pkg::*;

  MemReadAccessReq  icReq;
  MemAccessReqAck   icReqAck;
  MemAccessReq      dcReq;
  MemAccessReqAck   dcReqAck;
  MemAccessReq      memReq;
  MemAccessSerial   memReqSerial;
  MemWriteSerial    memReqWSerial;
  logic             memReqReady;
  MemAccessResult   memReadResult;
  MemAccessResponse memWriteResponse;
  MemAccessResult   icReadResult;
  MemAccessResult   dcReadResult;
  MemAccessResponse dcWriteResponse;
  logic             protocolError;

  modport slave (
    input  icReq, dcReq, memReqReady, memReadResult, memWriteResponse,
    output icReqAck, dcReqAck, memReq, memReqSerial, memReqWSerial,
           icReadResult, dcReadResult, dcWriteResponse, protocolError
  );

  modport master (
    output icReq, dcReq, memReqReady, memReadResult, memWriteResponse,
    input  icReqAck, dcReqAck, memReq, memReqSerial, memReqWSerial,
           icReadResult, dcReadResult, dcWriteResponse, protocolError
  );
endinterface

// File: rtl/mem_access_arbiter_serial_free_list.sv
// Allocation bitmap for transaction serials; offers the lowest free index taken
// from the registered vector, so a serial freed this cycle is reusable next cycle.
module serial_free_list #(
  parameter int NUM = 3,
  parameter int W   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           alloc,
  input  logic           free_en,
  input  logic [W-1:0]   free_idx,
  output logic           any_free,
  output logic [W-1:0]   pick_idx,
  output logic [NUM-1:0] alloc_vec
);

  logic [NUM-1:0] alloc_vec_q, alloc_vec_d;

  always_comb begin
    pick_idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (!alloc_vec_q[i]) pick_idx = W'(i);
    end
    any_free = ~&alloc_vec_q;

    alloc_vec_d = alloc_vec_q;
    for (int i = 0; i < NUM; i++) begin
      if (free_en && (free_idx == W'(i))) alloc_vec_d[i] = 1'b0;
      if (alloc && (pick_idx == W'(i)))   alloc_vec_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alloc_vec_q <= '0;
    else     alloc_vec_q <= alloc_vec_d;
  end

  assign alloc_vec = alloc_vec_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates ICache reads and DCache reads/writes onto one registered memory
// request, allocating serials and routing results back to the owning requester.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
(
  input logic                clk,
  input logic                rst,
  mem_access_arbiter_if.slave bus
);

  localparam int RN = MEM_READ_SERIAL_NUM;
  localparam int WN = MEM_WRITE_SERIAL_NUM;

  MemAccessReq    out_q, out_d;
  MemAccessSerial out_serial_q, out_serial_d;
  MemWriteSerial  out_wserial_q, out_wserial_d;
  MemReqSource    rr_last_q, rr_last_d;
  logic [RN-1:0]  owner_q, owner_d;
  logic           protocol_error_q, protocol_error_d;

  logic           rd_any_free, wr_any_free;
  MemAccessSerial rd_pick;
  MemWriteSerial  wr_pick;
  logic [RN-1:0]  rd_alloc_vec;
  logic [WN-1:0]  wr_alloc_vec;

  logic can_load, dc_wr, ic_elig, dc_elig, gnt_ic, gnt_dc;
  logic rd_alloc, wr_alloc, rd_hit, rd_owner_dc, rd_legal, wr_hit, wr_legal;

  serial_free_list #(.NUM(RN), .W(MEM_SERIAL_W)) u_read_serials (
    .clk(clk), .rst(rst), .alloc(rd_alloc), .free_en(rd_legal),
    .free_idx(bus.memReadResult.serial), .any_free(rd_any_free),
    .pick_idx(rd_pick), .alloc_vec(rd_alloc_vec)
  );

  serial_free_list #(.NUM(WN), .W(MEM_WSERIAL_W)) u_write_serials (
    .clk(clk), .rst(rst), .alloc(wr_alloc), .free_en(wr_legal),
    .free_idx(bus.memWriteResponse.serial), .any_free(wr_any_free),
    .pick_idx(wr_pick), .alloc_vec(wr_alloc_vec)
  );

  always_comb begin
    can_load = !out_q.valid || bus.memReqReady;
    dc_wr    = bus.dcReq.we;
    ic_elig  = !rst && bus.icReq.valid && can_load && rd_any_free;
    dc_elig  = !rst && bus.dcReq.valid && can_load && (dc_wr ? wr_any_free : rd_any_free);

    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    if (ic_elig && dc_elig) begin
      if (rr_last_q == MEM_REQ_SRC_IC) gnt_dc = 1'b1;
      else                             gnt_ic = 1'b1;
    end else begin
      gnt_ic = ic_elig;
      gnt_dc = dc_elig;
    end
    rd_alloc = gnt_ic || (gnt_dc && !dc_wr);
    wr_alloc = gnt_dc && dc_wr;

    // Out-of-range serials never match an index, so they read as unallocated.
    rd_hit      = 1'b0;
    rd_owner_dc = 1'b0;
    for (int i = 0; i < RN; i++) begin
      if (bus.memReadResult.serial == MemAccessSerial'(i)) begin
        rd_hit      = rd_alloc_vec[i];
        rd_owner_dc = owner_q[i];
      end
    end
    wr_hit = 1'b0;
    for (int i = 0; i < WN; i++) begin
      if (bus.memWriteResponse.serial == MemWriteSerial'(i)) wr_hit = wr_alloc_vec[i];
    end
    rd_legal = !rst && bus.memReadResult.valid && rd_hit;
    wr_legal = !rst && bus.memWriteResponse.valid && wr_hit;

    protocol_error_d = protocol_error_q
                     | (!rst && bus.memReadResult.valid && !rd_hit)
                     | (!rst && bus.memWriteResponse.valid && !wr_hit);

    owner_d = owner_q;
    for (int i = 0; i < RN; i++) begin
      if (rd_alloc && (rd_pick == MemAccessSerial'(i))) owner_d[i] = gnt_dc;
    end

    rr_last_d = rr_last_q;
    if (gnt_ic) rr_last_d = MEM_REQ_SRC_IC;
    if (gnt_dc) rr_last_d = MEM_REQ_SRC_DC;

    out_d         = out_q;
    out_serial_d  = out_serial_q;
    out_wserial_d = out_wserial_q;
    if (out_q.valid && bus.memReqReady) out_d.valid = 1'b0;
    if (gnt_ic) begin
      out_d         = MemAccessReq'{valid: 1'b1, we: 1'b0, addr: bus.icReq.addr, data: '0};
      out_serial_d  = rd_pick;
      out_wserial_d = '0;
    end else if (gnt_dc) begin
      out_d         = bus.dcReq;
      out_d.valid   = 1'b1;
      out_serial_d  = dc_wr ? '0 : rd_pick;
      out_wserial_d = dc_wr ? wr_pick : '0;
    end

    bus.icReqAck = MemAccessReqAck'{ack: gnt_ic, serial: rd_pick, wserial: '0};
    bus.dcReqAck = MemAccessReqAck'{ack: gnt_dc, serial: rd_pick, wserial: wr_pick};

    bus.icReadResult       = bus.memReadResult;
    bus.icReadResult.valid = rd_legal && !rd_owner_dc;
    bus.dcReadResult       = bus.memReadResult;
    bus.dcReadResult.valid = rd_legal && rd_owner_dc;
    bus.dcWriteResponse       = bus.memWriteResponse;
    bus.dcWriteResponse.valid = wr_legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q            <= '0;
      out_serial_q     <= '0;
      out_wserial_q    <= '0;
      rr_last_q        <= MEM_REQ_SRC_IC;
      owner_q          <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      out_q            <= out_d;
      out_serial_q     <= out_serial_d;
      out_wserial_q    <= out_wserial_d;
      rr_last_q        <= rr_last_d;
      owner_q          <= owner_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign bus.memReq        = out_q;
  assign bus.memReqSerial  = out_serial_q;
  assign bus.memReqWSerial = out_wserial_q;
  assign bus.protocolError = protocol_error_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: acks/serials checked inline, issued
// memory requests checked against an expected queue as they drain.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  localparam int EXP_W = 1 + MEM_ADDR_W + MEM_DATA_W + MEM_SERIAL_W + MEM_WSERIAL_W;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  mem_access_arbiter_if bus ();

  mem_access_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack_req(input logic we, input logic [MEM_ADDR_W-1:0] addr,
                                                input logic [MEM_DATA_W-1:0] data,
                                                input logic [MEM_SERIAL_W-1:0] serial,
                                                input logic [MEM_WSERIAL_W-1:0] wserial);
    return {we, addr, data, serial, wserial};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic ic_drive(input logic v, input logic [MEM_ADDR_W-1:0] a);
    bus.icReq = '{valid: v, addr: a};
  endtask

  task automatic dc_drive(input logic v, input logic we, input logic [MEM_ADDR_W-1:0] a,
                          input logic [MEM_DATA_W-1:0] d);
    bus.dcReq = '{valid: v, we: we, addr: a, data: d};
  endtask

  task automatic rd_res(input logic v, input logic [MEM_SERIAL_W-1:0] s, input logic [MEM_DATA_W-1:0] d);
    bus.memReadResult = '{valid: v, serial: s, data: d};
  endtask

  task automatic wr_resp(input logic v, input logic [MEM_WSERIAL_W-1:0] s);
    bus.memWriteResponse = '{valid: v, serial: s};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // scoreboard: every drained memory request must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.memReq.valid && bus.memReqReady) begin
      if (exp_q.size() == 0) begin
        chk("memreq_unexpected", 128'd1, 128'd0);
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        chk("memreq", pack_req(bus.memReq.we, bus.memReq.addr, bus.memReq.data,
                               bus.memReqSerial, bus.memReqWSerial), e);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ic_drive(1'b1, 32'h1000);
    dc_drive(1'b0, 1'b0, '0, '0);
    rd_res(1'b0, '0, '0);
    wr_resp(1'b0, '0);
    bus.memReqReady = 1'b1;

    // reset state
    at_neg();
    chk("rst_memreq_valid", bus.memReq.valid, 0);
    chk("rst_prot_err", bus.protocolError, 0);
    chk("rst_ic_ack", bus.icReqAck.ack, 0);
    chk("rst_dc_ack", bus.dcReqAck.ack, 0);
    chk("rst_ic_res", bus.icReadResult.valid, 0);
    tick();
    rst = 1'b0;

    // single IC read, result routed to ICache
    at_neg();
    chk("t1_ic_ack", bus.icReqAck.ack, 1);
    chk("t1_ic_serial", bus.icReqAck.serial, 0);
    chk("t1_dc_ack", bus.dcReqAck.ack, 0);
    exp_q.push_back(pack_req(1'b0, 32'h1000, '0, 2'd0, 2'd0));
    tick();
    ic_drive(1'b0, '0);
    at_neg();
    chk("t1_memreq_valid", bus.memReq.valid, 1);
    chk("t1_memreq_addr", bus.memReq.addr, 32'h1000);
    chk("t1_memreq_serial", bus.memReqSerial, 0);
    tick();
    rd_res(1'b1, 2'd0, 64'hDEADBEEF0);
    at_neg();
    chk("t1_ic_res_valid", bus.icReadResult.valid, 1);
    chk("t1_ic_res_data", bus.icReadResult.data, 64'hDEADBEEF0);
    chk("t1_dc_res_valid", bus.dcReadResult.valid, 0);
    tick();
    rd_res(1'b0, '0, '0);

    // IC and DC together: DC first after reset, then IC
    do_reset();
    ic_drive(1'b1, 32'h2000);
    dc_drive(1'b1, 1'b0, 32'h3000, '0);
    at_neg();
    chk("t2_dc_ack", bus.dcReqAck.ack, 1);
    chk("t2_dc_serial", bus.dcReqAck.serial, 0);
    chk("t2_ic_ack0", bus.icReqAck.ack, 0);
    exp_q.push_back(pack_req(1'b0, 32'h3000, '0, 2'd0, 2'd0));
    tick();
    dc_drive(1'b0, 1'b0, '0, '0);
    at_neg();
    chk("t2_ic_ack", bus.icReqAck.ack, 1);
    chk("t2_ic_serial", bus.icReqAck.serial, 1);
    exp_q.push_back(pack_req(1'b0, 32'h2000, '0, 2'd1, 2'd0));
    tick();
    ic_drive(1'b0, '0);

    // read serials exhausted: read held, write still granted
    dc_drive(1'b1, 1'b0, 32'h4000, '0);
    at_neg();
    chk("t3_dc_rd_ack", bus.dcReqAck.ack, 1);
    chk("t3_dc_rd_serial", bus.dcReqAck.serial, 2);
    exp_q.push_back(pack_req(1'b0, 32'h4000, '0, 2'd2, 2'd0));
    tick();
    ic_drive(1'b1, 32'h5000);
    dc_drive(1'b1, 1'b1, 32'h6000, 64'h55);
    at_neg();
    chk("t3_ic_full", bus.icReqAck.ack, 0);
    chk("t3_dc_wr_ack", bus.dcReqAck.ack, 1);
    chk("t3_dc_wserial", bus.dcReqAck.wserial, 0);
    exp_q.push_back(pack_req(1'b1, 32'h6000, 64'h55, 2'd0, 2'd0));
    tick();
    dc_drive(1'b0, 1'b0, '0, '0);
    rd_res(1'b1, 2'd1, 64'h1111);
    at_neg();
    chk("t3_ic_same_cycle", bus.icReqAck.ack, 0);
    chk("t3_res1_ic_valid", bus.icReadResult.valid, 1);
    chk("t3_res1_ic_data", bus.icReadResult.data, 64'h1111);
    tick();
    rd_res(1'b0, '0, '0);
    at_neg();
    chk("t3_ic_ack_next", bus.icReqAck.ack, 1);
    chk("t3_ic_serial", bus.icReqAck.serial, 1);
    exp_q.push_back(pack_req(1'b0, 32'h5000, '0, 2'd1, 2'd0));
    tick();
    ic_drive(1'b0, '0);
    rd_res(1'b1, 2'd0, 64'h2222);
    wr_resp(1'b1, 2'd0);
    at_neg();
    chk("t3_dc_res_valid", bus.dcReadResult.valid, 1);
    chk("t3_dc_res_data", bus.dcReadResult.data, 64'h2222);
    chk("t3_ic_res_quiet", bus.icReadResult.valid, 0);
    chk("t3_wr_resp_valid", bus.dcWriteResponse.valid, 1);
    chk("t3_wr_resp_serial", bus.dcWriteResponse.serial, 0);
    tick();
    rd_res(1'b0, '0, '0);
    wr_resp(1'b0, '0);

    // back-pressure from memory
    bus.memReqReady = 1'b0;
    dc_drive(1'b1, 1'b1, 32'h7000, 64'h77);
    at_neg();
    chk("t4_wr_ack", bus.dcReqAck.ack, 1);
    chk("t4_wr_wserial", bus.dcReqAck.wserial, 0);
    exp_q.push_back(pack_req(1'b1, 32'h7000, 64'h77, 2'd0, 2'd0));
    tick();
    dc_drive(1'b1, 1'b1, 32'h8000, 64'h88);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t4_stall_ack", bus.dcReqAck.ack, 0);
      chk("t4_stall_valid", bus.memReq.valid, 1);
      chk("t4_stall_addr", bus.memReq.addr, 32'h7000);
      tick();
    end
    bus.memReqReady = 1'b1;
    at_neg();
    chk("t4_b2b_ack", bus.dcReqAck.ack, 1);
    chk("t4_b2b_wserial", bus.dcReqAck.wserial, 1);
    exp_q.push_back(pack_req(1'b1, 32'h8000, 64'h88, 2'd0, 2'd1));
    tick();
    dc_drive(1'b0, 1'b0, '0, '0);
    at_neg();
    chk("t4_b2b_addr", bus.memReq.addr, 32'h8000);
    tick();

    // responses for free or out-of-range serials
    rd_res(1'b1, 2'd2, 64'h3333);
    at_neg();
    chk("t5_legal_dc_res", bus.dcReadResult.valid, 1);
    tick();
    rd_res(1'b1, 2'd2, 64'h4444);
    at_neg();
    chk("t5_free_ic_res", bus.icReadResult.valid, 0);
    chk("t5_free_dc_res", bus.dcReadResult.valid, 0);
    chk("t5_err_not_yet", bus.protocolError, 0);
    tick();
    rd_res(1'b1, 2'd3, 64'h5555);
    at_neg();
    chk("t5_err_set", bus.protocolError, 1);
    chk("t5_oor_ic_res", bus.icReadResult.valid, 0);
    chk("t5_oor_dc_res", bus.dcReadResult.valid, 0);
    tick();
    rd_res(1'b0, '0, '0);
    repeat (3) tick();
    at_neg();
    chk("t5_err_sticky", bus.protocolError, 1);
    tick();

    // reset in the middle of traffic
    ic_drive(1'b1, 32'h9000);
    at_neg();
    chk("t6_ic_ack", bus.icReqAck.ack, 1);
    chk("t6_ic_serial", bus.icReqAck.serial, 0);
    exp_q.push_back(pack_req(1'b0, 32'h9000, '0, 2'd0, 2'd0));
    tick();
    rst = 1'b1;
    ic_drive(1'b1, 32'hA000);
    #1;
    chk("t6_rst_memreq", bus.memReq.valid, 0);
    chk("t6_rst_err", bus.protocolError, 0);
    chk("t6_rst_ic_ack", bus.icReqAck.ack, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    at_neg();
    chk("t6_post_ack", bus.icReqAck.ack, 1);
    chk("t6_post_serial", bus.icReqAck.serial, 0);
    exp_q.push_back(pack_req(1'b0, 32'hA000, '0, 2'd0, 2'd0));
    tick();
    ic_drive(1'b0, '0);
    at_neg();
    tick();
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Sits between the cache miss handlers and the external memory port. It arbitrates read requests from the ICache and read/write requests from the DCache MSHRs. It allocates read serials (MemAccessSerial) and write serials (MemWriteSerial) from free lists and issues one registered request per cycle to memory. It routes each returned read result or write response back to the requester that owns the serial.

Parameters:
READ_SERIAL_NUM, MSHR_NUM+1, number of outstanding read transactions (serials 0..READ_SERIAL_NUM-1).
WRITE_SERIAL_NUM, MSHR_NUM, number of outstanding write transactions.

Ports:
clk  in  1  clock; sole clock domain.
rst  in  1  asynchronous, active-high reset.
icReq  in  MemReadAccessReq  ICache read request.
icReqAck  out  MemAccessReqAck  ICache accept; .serial is valid when .ack=1.
dcReq  in  MemAccessReq  DCache MSHR request; we=1 means write.
dcReqAck  out  MemAccessReqAck  DCache accept; carries .serial or .wserial.
memReq  out  MemAccessReq  registered request to memory.
memReqSerial  out  MemAccessSerial  read serial of memReq.
memReqWSerial  out  MemWriteSerial  write serial of memReq.
memReqReady  in  1  memory accepts memReq this cycle.
memReadResult  in  MemAccessResult  read data returned from memory.
memWriteResponse  in  MemAccessResponse  write completion from memory.
icReadResult  out  MemAccessResult  forwarded read data for ICache-owned serials.
dcReadResult  out  MemAccessResult  forwarded read data for DCache-owned serials.
dcWriteResponse  out  MemAccessResponse  forwarded write completion.
protocolError  out  1  sticky; a response arrived for a serial that is not allocated.

Behaviour:
- Reset (asynchronous): all serials free; no outstanding entries; memReq.valid=0; rrLast=IC; protocolError=0. All acks and forwarded valids are 0.
- Output register (outReg): holds one request. It drains when memReq.valid && memReqReady. canLoad = !outReg.valid || memReqReady, so a back-to-back request can be loaded in the same cycle the current one drains.
- Eligibility:
  - IC is eligible when icReq.valid, canLoad, and a read serial is free.
  - DC read is eligible when canLoad and a read serial is free.
  - DC write is eligible when canLoad and a write serial is free.
- Arbitration: if both are eligible, grant the one not in rrLast, then update rrLast to the winner. Otherwise grant the single eligible requester. At most one grant per cycle.
- Ack timing: ack is combinational in the grant cycle. The serial returned is the lowest-index free serial taken from the registered free vector. The request is loaded into outReg at the clock edge, so memReq is visible one cycle after ack. A requester must hold valid until it sees ack.
- Read owner table: one bit per read serial (IC=0, DC=1), written on allocation.
- Read result path (memReadResult.valid):
  - Look up the owner of .serial.
  - Drive icReadResult or dcReadResult with the same cycle's data (combinational, 0-cycle latency).
  - Free the serial at the clock edge.
- Write response path: memWriteResponse.valid is forwarded to dcWriteResponse combinationally, and the write serial is freed at the clock edge.
- Same-cycle free and allocate: a serial freed in cycle N is not reallocatable until cycle N+1, because allocation uses the registered free vector.
- Full: when no serial of the required kind is free, the corresponding ack stays 0. There is no queuing, and the other requester may still be granted.
- Illegal response: a response for a free serial, or with a serial >= READ_SERIAL_NUM, is dropped (no forwarded valid) and sets protocolError.
- Simultaneous read result and write response: both are handled in the same cycle (independent paths).

Decomposition:
- Shared package CacheSystemTypes: add MEM_READ_SERIAL_NUM and MEM_WRITE_SERIAL_NUM, plus a MemReqSource enum {MEM_REQ_SRC_IC, MEM_REQ_SRC_DC}.
- Reuse the existing MemAccessReq, MemReadAccessReq, MemAccessReqAck, MemAccessResult and MemAccessResponse types.
- Sub-module serial_free_list, instantiated twice (read and write). Parameters: NUM. It provides a lowest-free pick, alloc/free ports, and allocated-vector output.

Test Plan:
- Single IC read, addr 0x1000, memReqReady=1 -> icReqAck.ack=1 with serial 0 in cycle 0. memReq{valid=1, we=0, addr=0x1000, serial=0} in cycle 1. A result with serial 0 and data 0xDEAD_BEEF_0 appears on icReadResult, not dcReadResult.
- IC and DC read together for 2 consecutive cycles after reset -> DC granted first (rrLast=IC) with serial 0. In the next cycle IC is granted with serial 1.
- Three reads outstanding with no results -> the fourth read is not acked while a DC write is still acked with wserial 0. A read result with serial 1 arrives in cycle N -> the held read is acked in cycle N+1 with serial 1.
- memReqReady=0 for 3 cycles with outReg full -> no acks and memReq stable. When ready=1, the next request is loaded in the same cycle the current one drains.
- memReadResult with serial 2 while serial 2 is free -> no forwarded valid, and protocolError=1 remains set until rst.
- Assert rst mid-transaction with 2 serials outstanding -> outputs clear immediately. After reset release, the next request receives serial 0.
